// File: rtl/bcd_down_counter_if.sv
// rtl/bcd_down_counter_if.sv - control and status bundle for the BCD countdown timer
// master drives load/start/pause/tick; slave (the counter) returns count and flags.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic                  tick;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  borrow_out;
  logic                  load_err;

  modport master (
    output load, load_value, start, pause, tick,
    input  q, running, done, borrow_out, load_err
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output q, running, done, borrow_out, load_err
  );
endinterface

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - multi-digit BCD countdown timer with load, start/pause and terminal borrow
// Inputs are prioritised load > pause > start > tick; all outputs are registered.
module bcd_down_counter #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bcd_down_counter_if.slave    bus
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    reload_q, reload_d;
  logic            borrow_q, borrow_d;
  logic            err_q, err_d;

  logic [W-1:0]    dec_val;
  logic [DIGITS:0] borrow_chain;
  logic [DIGITS-1:0] digit_ok;
  logic            load_ok;

  // Ripple borrow: a digit decrements only while every lower digit is rolling 0 -> 9.
  assign borrow_chain[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] nib;
    assign nib                  = count_q[4*i +: 4];
    assign dec_val[4*i +: 4]    = !borrow_chain[i] ? nib :
                                  (nib == 4'd0) ? 4'd9 : nib - 4'd1;
    assign borrow_chain[i+1]    = borrow_chain[i] & (nib == 4'd0);
    assign digit_ok[i]          = bus.load_value[4*i +: 4] <= 4'd9;
  end

  assign load_ok = &digit_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        count_d  = bus.load_value;
        reload_d = bus.load_value;
        state_d  = S_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.pause) begin
      if (state_q == S_RUN) state_d = S_PAUSED;
    end else if (bus.start) begin
      if (state_q == S_IDLE || state_q == S_PAUSED)
        state_d = (count_q == '0) ? S_DONE : S_RUN;
    end else if (bus.tick && state_q == S_RUN) begin
      if (count_q == ONE) begin
        borrow_d = 1'b1;
        // A zero reload value would restart at zero, so it stops like the one-shot mode.
        if (AUTO_RELOAD && reload_q != '0) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = S_DONE;
        end
      end else begin
        count_d = dec_val;
      end
    end
  end

  assign bus.q          = count_q;
  assign bus.running    = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.borrow_out = borrow_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - scoreboard bench for one-shot and auto-reload countdown timers
// Driver pushes model predictions per cycle; a monitor pops and compares after each edge.
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  typedef struct packed {
    logic [W-1:0] q;
    logic         running;
    logic         done;
    logic         borrow_out;
    logic         load_err;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bcd_down_counter_if #(.DIGITS(DIGITS)) bus0 ();
  bcd_down_counter_if #(.DIGITS(DIGITS)) bus1 ();

  bcd_down_counter #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  bcd_down_counter #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  obs_t expq0[$];
  obs_t expq1[$];
  int   cnt[2];
  int   rel[2];
  int   st[2];
  bit   bor[2];
  bit   err[2];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic obs_t predict(input int k);
    obs_t o;
    o.q          = to_bcd(cnt[k]);
    o.running    = (st[k] == M_RUN);
    o.done       = (st[k] == M_DONE);
    o.borrow_out = bor[k];
    o.load_err   = err[k];
    return o;
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    if (k == 0) o = '{bus0.q, bus0.running, bus0.done, bus0.borrow_out, bus0.load_err};
    else        o = '{bus1.q, bus1.running, bus1.done, bus1.borrow_out, bus1.load_err};
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; rel[k] = 0; st[k] = M_IDLE; bor[k] = 0; err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit ar, input bit ld, input logic [W-1:0] lv,
                            input bit s, input bit p, input bit t);
    int v, pw, nib;
    bit ok;
    bor[k] = 0;
    err[k] = 0;
    if (ld) begin
      ok = 1; v = 0; pw = 1;
      for (int i = 0; i < DIGITS; i++) begin
        nib = int'(lv[4*i +: 4]);
        if (nib > 9) ok = 0;
        v  = v + nib * pw;
        pw = pw * 10;
      end
      if (ok) begin
        cnt[k] = v; rel[k] = v; st[k] = M_IDLE;
      end else begin
        err[k] = 1;
      end
    end else if (p) begin
      if (st[k] == M_RUN) st[k] = M_PAUSED;
    end else if (s) begin
      if (st[k] == M_IDLE || st[k] == M_PAUSED) st[k] = (cnt[k] == 0) ? M_DONE : M_RUN;
    end else if (t && st[k] == M_RUN) begin
      if (cnt[k] == 1) begin
        bor[k] = 1;
        if (ar && rel[k] != 0) cnt[k] = rel[k];
        else begin cnt[k] = 0; st[k] = M_DONE; end
      end else begin
        cnt[k] = cnt[k] - 1;
      end
    end
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got q=%h run=%b done=%b borrow=%b lerr=%b, want q=%h run=%b done=%b borrow=%b lerr=%b",
               name, $time, act.q, act.running, act.done, act.borrow_out, act.load_err,
               exp.q, exp.running, exp.done, exp.borrow_out, exp.load_err);
    end
  endtask

  task automatic drive(input bit ld, input logic [W-1:0] lv, input bit s, input bit p, input bit t);
    bus0.load = ld; bus0.load_value = lv; bus0.start = s; bus0.pause = p; bus0.tick = t;
    bus1.load = ld; bus1.load_value = lv; bus1.start = s; bus1.pause = p; bus1.tick = t;
  endtask

  task automatic apply(input bit ld, input logic [W-1:0] lv, input bit s, input bit p, input bit t);
    drive(ld, lv, s, p, t);
    model_step(0, 1'b0, ld, lv, s, p, t);
    model_step(1, 1'b1, ld, lv, s, p, t);
    expq0.push_back(predict(0));
    expq1.push_back(predict(1));
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset lands between edges so the immediate (asynchronous) clear can be observed.
  task automatic mid_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_ar0", sample(0), predict(0));
    check("async_reset_ar1", sample(1), predict(1));
    expq0.push_back(predict(0));
    expq1.push_back(predict(1));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq0.size() > 0) check("cycle_ar0", sample(0), expq0.pop_front());
      if (expq1.size() > 0) check("cycle_ar1", sample(1), expq1.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    expq0.push_back(predict(0));
    expq1.push_back(predict(1));
    @(negedge clk);
    reset_n = 1'b1;

    apply(1'b1, 8'h25, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(26);

    apply(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(1);

    apply(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);

    apply(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    apply(1'b0, '0, 1'b0, 1'b1, 1'b1);
    ticks(2);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(1);

    apply(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(6);

    apply(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    mid_reset();
    ticks(3);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b1, 1'b0, 1'b0);
    ticks(3);

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] lv;
      lv = W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) lv = to_bcd(int'($urandom_range(0, 12)));
      apply($urandom_range(0, 9) == 0, lv, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #2;
    vectors++;
    if (expq0.size() != 0 || expq1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", expq0.size(), expq1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
